// File: rtl/ks_serial_wide_adder.sv
`default_nettype none
// ============================================================================
// Module   : ks_serial_wide_adder (with 8-bit Kogge-Stone core ks_adder8)
// Function : NBYTES-wide adder, one byte per cycle through one KS core.
//            KS_SIGNED_OVF_EN enables the signed overflow flag.
// Revision : 1.0 - initial release
// ============================================================================

module ks_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [8:0] s,
  output logic [7:0] c
);
  logic [7:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3;

  // cin is folded into bit 0's generate, so each prefix G[i] is the carry out of bit i
  assign w_p0 = a ^ b;
  assign w_g0 = (a & b) | {7'b0, w_p0[0] & cin};
  assign w_g1 = w_g0 | (w_p0 & {w_g0[6:0], 1'b0});
  assign w_p1 = w_p0 & {w_p0[6:0], 1'b0};
  assign w_g2 = w_g1 | (w_p1 & {w_g1[5:0], 2'b0});
  assign w_p2 = w_p1 & {w_p1[5:0], 2'b0};
  assign w_g3 = w_g2 | (w_p2 & {w_g2[3:0], 4'b0});

  assign c = {w_g3[6:0], cin};
  assign s = {w_g3[7], w_p0 ^ c};
endmodule

module ks_serial_wide_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int c_W  = 8 * NBYTES;
  localparam int c_KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [c_KW-1:0] c_KLAST = c_KW'(NBYTES - 1);
  localparam logic [c_KW-1:0] c_KONE  = c_KW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_W-1:0]    r_a, r_b;
  logic [c_KW-1:0]   r_k;
  logic              r_carry;
  logic              r_cout;
  logic [7:0]        r_sum_b [NBYTES];
  logic [8:0]        w_s;

`ifdef KS_SIGNED_OVF_EN
  logic [7:0]        w_c;
  logic              r_ovf;
`endif

  ks_adder8 u_core (
    .a   (r_a[7:0]),
    .b   (r_b[7:0]),
    .cin (r_carry),
    .s   (w_s),
`ifdef KS_SIGNED_OVF_EN
    .c   (w_c)
`else
    .c   ()
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)       w_state_nxt = S_RUN;
      S_RUN:   if (r_k == c_KLAST) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)      w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  // Operands shift down a byte per RUN cycle so the core always sees bits [7:0]
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
    end else if (r_state == S_RUN) begin
      r_a <= r_a >> 8;
      r_b <= r_b >> 8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef KS_SIGNED_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == S_IDLE && in_valid) begin
      r_k     <= '0;
      r_carry <= cin;
    end else if (r_state == S_RUN) begin
      r_k     <= r_k + c_KONE;
      r_carry <= w_s[8];
      if (r_k == c_KLAST) begin
        r_cout <= w_s[8];
`ifdef KS_SIGNED_OVF_EN
        r_ovf  <= w_c[7] ^ w_s[8];
`endif
      end
    end
  end

  for (genvar i = 0; i < NBYTES; i++) begin : g_byte
    always_ff @(posedge clk) begin
      if (rst)
        r_sum_b[i] <= 8'h00;
      else if (r_state == S_RUN && r_k == c_KW'(i))
        r_sum_b[i] <= w_s[7:0];
    end
    assign sum[8*i +: 8] = r_sum_b[i];
  end

  assign cout = r_cout;
`ifdef KS_SIGNED_OVF_EN
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire
